// File: rtl/div_arb_pkg.sv
// Shared types for the divider arbiter: op codes, FSM states,
// divide-by-zero quotient and small op-decode helpers.
package div_arb_pkg;

    typedef enum logic [1:0] {
        OP_DIV  = 2'b00,
        OP_DIVU = 2'b01,
        OP_REM  = 2'b10,
        OP_REMU = 2'b11
    } op_e;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_LAUNCH = 2'd1;
    localparam state_t ST_WAIT   = 2'd2;
    localparam state_t ST_RESP   = 2'd3;

    // Wide enough for any supported DATA_WIDTH; sliced by the user.
    localparam logic [63:0] DIV_BY_ZERO_Q = '1;

    function automatic logic op_signed(op_e op);
        return (op == OP_DIV) || (op == OP_REM);
    endfunction

    function automatic logic op_rem(op_e op);
        return (op == OP_REM) || (op == OP_REMU);
    endfunction

endpackage

// File: rtl/div_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first set request at or after
// the pointer, wrapping to the lowest set request below it.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx,
    output logic          found
);

    logic          hi_hit;
    logic [IW-1:0] hi_idx;
    logic [IW-1:0] lo_idx;

    // Descending scan leaves the lowest qualifying index in each slot.
    always_comb begin
        hi_hit = 1'b0;
        hi_idx = '0;
        lo_idx = '0;
        for (int j = N - 1; j >= 0; j--) begin
            if (req[j]) begin
                lo_idx = IW'(j);
                if (IW'(j) >= ptr) begin
                    hi_hit = 1'b1;
                    hi_idx = IW'(j);
                end
            end
        end
    end

    assign found = |req;
    assign idx   = hi_hit ? hi_idx : lo_idx;

    always_comb begin
        grant = '0;
        for (int j = 0; j < N; j++) begin
            grant[j] = found && (idx == IW'(j));
        end
    end

endmodule

// File: rtl/div_arbiter.sv
// Shares one unsigned iterative divider between N_REQ requesters and
// layers RISC-V DIV/DIVU/REM/REMU sign and divide-by-zero rules on top.
module div_arbiter
    import div_arb_pkg::*;
#(
    parameter int N_REQ      = 4,
    parameter int DATA_WIDTH = 32
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic [N_REQ-1:0]                    req_valid_i,
    input  logic [N_REQ-1:0][1:0]               req_op_i,
    input  logic [N_REQ-1:0][DATA_WIDTH-1:0]    req_dividend_i,
    input  logic [N_REQ-1:0][DATA_WIDTH-1:0]    req_divisor_i,
    output logic [N_REQ-1:0]                    req_ready_o,
    output logic [N_REQ-1:0]                    rsp_valid_o,
    output logic [DATA_WIDTH-1:0]               rsp_data_o,
    output logic                                busy_o,
    output logic                                div_enable_o,
    output logic [DATA_WIDTH-1:0]               div_dividend_o,
    output logic [DATA_WIDTH-1:0]               div_divisor_o,
    input  logic                                div_finished_i,
    input  logic [DATA_WIDTH-1:0]               div_quotient_i,
    input  logic [DATA_WIDTH-1:0]               div_remainder_i
);

    localparam int IW  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int MSB = DATA_WIDTH - 1;

    state_t                state;
    logic [IW-1:0]         ptr;
    logic [IW-1:0]         gid;
    op_e                   op_q;
    logic                  neg_a;
    logic                  neg_b;
    logic [DATA_WIDTH-1:0] result;

    logic [N_REQ-1:0]      grant;
    logic [IW-1:0]         gidx;
    logic                  any_req;
    logic [IW-1:0]         ptr_next;

    op_e                   op_sel;
    logic [DATA_WIDTH-1:0] a_sel;
    logic [DATA_WIDTH-1:0] b_sel;
    logic                  a_neg;
    logic                  b_neg;
    logic [DATA_WIDTH-1:0] q_fix;
    logic [DATA_WIDTH-1:0] r_fix;

    rr_arbiter #(
        .N  (N_REQ),
        .IW (IW)
    ) u_rr (
        .req   (req_valid_i),
        .ptr   (ptr),
        .grant (grant),
        .idx   (gidx),
        .found (any_req)
    );

    assign op_sel = op_e'(req_op_i[gidx]);
    assign a_sel  = req_dividend_i[gidx];
    assign b_sel  = req_divisor_i[gidx];
    assign a_neg  = op_signed(op_sel) & a_sel[MSB];
    assign b_neg  = op_signed(op_sel) & b_sel[MSB];

    assign ptr_next = (gidx == IW'(N_REQ - 1)) ? '0 : gidx + IW'(1);

    // MIN / -1 needs no special case: |MIN| wraps back to MIN.
    assign q_fix = (neg_a ^ neg_b) ? -div_quotient_i : div_quotient_i;
    assign r_fix = neg_a ? -div_remainder_i : div_remainder_i;

    assign req_ready_o  = (state == ST_IDLE && !reset) ? grant : '0;
    assign busy_o       = (state != ST_IDLE);
    assign div_enable_o = (state == ST_LAUNCH);
    assign rsp_data_o   = (state == ST_RESP) ? result : '0;

    always_comb begin
        rsp_valid_o = '0;
        for (int i = 0; i < N_REQ; i++) begin
            rsp_valid_o[i] = (state == ST_RESP) && (gid == IW'(i));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= ST_IDLE;
            ptr            <= '0;
            gid            <= '0;
            op_q           <= OP_DIV;
            neg_a          <= 1'b0;
            neg_b          <= 1'b0;
            result         <= '0;
            div_dividend_o <= '0;
            div_divisor_o  <= '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (any_req) begin
                        gid            <= gidx;
                        op_q           <= op_sel;
                        ptr            <= ptr_next;
                        neg_a          <= a_neg;
                        neg_b          <= b_neg;
                        div_dividend_o <= a_neg ? -a_sel : a_sel;
                        div_divisor_o  <= b_neg ? -b_sel : b_sel;
                        if (b_sel == '0) begin
                            result <= op_rem(op_sel) ? a_sel
                                    : DIV_BY_ZERO_Q[DATA_WIDTH-1:0];
                            state  <= ST_RESP;
                        end else begin
                            state  <= ST_LAUNCH;
                        end
                    end
                end
                ST_LAUNCH: begin
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (div_finished_i) begin
                        result <= op_rem(op_q) ? r_fix : q_fix;
                        state  <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_arbiter.sv
// Self-checking bench for div_arbiter with a behavioural divider model
// and a signed-arithmetic reference for RISC-V divide semantics.
module tb_div_arbiter;

    localparam int N = 4;
    localparam int W = 32;
    localparam logic [1:0] DIV  = 2'b00;
    localparam logic [1:0] DIVU = 2'b01;
    localparam logic [1:0] REM  = 2'b10;
    localparam logic [1:0] REMU = 2'b11;
    localparam logic [W-1:0] MINV = 32'h8000_0000;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [N-1:0] req_valid = '0;
    logic [N-1:0][1:0] req_op = '0;
    logic [N-1:0][W-1:0] req_dividend = '0;
    logic [N-1:0][W-1:0] req_divisor = '0;
    logic [N-1:0] req_ready;
    logic [N-1:0] rsp_valid;
    logic [W-1:0] rsp_data;
    logic busy;
    logic div_enable;
    logic [W-1:0] div_dividend;
    logic [W-1:0] div_divisor;
    logic div_finished;
    logic fin_model = 1'b0;
    logic stray = 1'b0;
    logic [W-1:0] div_quotient = '0;
    logic [W-1:0] div_remainder = '0;
    logic div_busy = 1'b0;
    int div_cnt = 0;
    int lat_min = 1;
    int cyc = 0;
    int passed = 0;
    int total = 0;

    div_arbiter #(.N_REQ(N), .DATA_WIDTH(W)) dut (
        .clk             (clk),
        .reset           (reset),
        .req_valid_i     (req_valid),
        .req_op_i        (req_op),
        .req_dividend_i  (req_dividend),
        .req_divisor_i   (req_divisor),
        .req_ready_o     (req_ready),
        .rsp_valid_o     (rsp_valid),
        .rsp_data_o      (rsp_data),
        .busy_o          (busy),
        .div_enable_o    (div_enable),
        .div_dividend_o  (div_dividend),
        .div_divisor_o   (div_divisor),
        .div_finished_i  (div_finished),
        .div_quotient_i  (div_quotient),
        .div_remainder_i (div_remainder)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    assign div_finished = fin_model | stray;

    // Unsigned divider with random latency.
    always @(posedge clk) begin
        fin_model <= 1'b0;
        if (reset) begin
            div_busy <= 1'b0;
            div_cnt  <= 0;
        end else if (div_enable) begin
            div_busy      <= 1'b1;
            div_cnt       <= int'($urandom_range(lat_min, lat_min + 4));
            div_quotient  <= (div_divisor == 0) ? '1 : div_dividend / div_divisor;
            div_remainder <= (div_divisor == 0) ? div_dividend : div_dividend % div_divisor;
        end else if (div_busy) begin
            if (div_cnt == 0) begin
                fin_model <= 1'b1;
                div_busy  <= 1'b0;
            end else begin
                div_cnt <= div_cnt - 1;
            end
        end
    end

    function automatic logic [W-1:0] ref_div(logic [1:0] op, logic [W-1:0] a, logic [W-1:0] b);
        logic signed [W-1:0] sa;
        logic signed [W-1:0] sb;
        logic ovf;
        sa = a;
        sb = b;
        ovf = (a == MINV) && (b == '1);
        if (b == 0) return op[1] ? a : '1;
        case (op)
            DIV:  return ovf ? MINV : W'(sa / sb);
            DIVU: return a / b;
            REM:  return ovf ? '0 : W'(sa % sb);
            default: return a % b;
        endcase
    endfunction

    task automatic run_one(input int r, input logic [1:0] op,
                           input logic [W-1:0] a, input logic [W-1:0] b,
                           output logic [W-1:0] data, output int t_rdy,
                           output int t_en, output int t_rsp, output bit other);
        logic [N-1:0] mask;
        mask = ~(N'(1) << r);
        t_rdy = -1; t_en = -1; t_rsp = -1; data = '0; other = 1'b0;
        req_op[r] = op;
        req_dividend[r] = a;
        req_divisor[r] = b;
        req_valid[r] = 1'b1;
        for (int n = 0; n < 300 && t_rsp < 0; n++) begin
            @(negedge clk);
            if ((rsp_valid & mask) !== '0) other = 1'b1;
            if (div_enable === 1'b1 && t_en < 0) t_en = cyc;
            if (rsp_valid[r] === 1'b1) begin
                t_rsp = cyc;
                data = rsp_data;
            end
            if (t_rdy < 0 && req_ready[r] === 1'b1) begin
                t_rdy = cyc;
                @(posedge clk);
                #1 req_valid[r] = 1'b0;
            end
        end
        req_valid[r] = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        req_valid = '1;
        req_dividend = {N{32'd9}};
        req_divisor = {N{32'd3}};
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++;
        if (req_ready !== '0) $display("FAIL reset_ready got=%b exp=0", req_ready);
        else passed++;
        total++;
        if ({busy, div_enable, rsp_valid} !== '0)
            $display("FAIL reset_ctrl got busy=%b en=%b rsp=%b exp=0", busy, div_enable, rsp_valid);
        else passed++;
        total++;
        if ({rsp_data, div_dividend, div_divisor} !== '0)
            $display("FAIL reset_data got %h %h %h exp=0", rsp_data, div_dividend, div_divisor);
        else passed++;
        req_valid = '0;
        @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic test_unsigned();
        logic [W-1:0] d;
        int tr, te, ts;
        bit o;
        run_one(0, DIVU, 32'd100, 32'd7, d, tr, te, ts, o);
        total++;
        if (d !== 32'd14 || o) $display("FAIL divu_data got=%0d exp=14 other=%b", d, o);
        else passed++;
        total++;
        if (tr < 0 || te != tr + 1 || ts <= te)
            $display("FAIL divu_timing got rdy=%0d en=%0d rsp=%0d exp en=rdy+1", tr, te, ts);
        else passed++;
        run_one(0, REMU, 32'd100, 32'd7, d, tr, te, ts, o);
        total++;
        if (d !== 32'd2 || o) $display("FAIL remu_data got=%0d exp=2 other=%b", d, o);
        else passed++;
    endtask

    task automatic test_signed();
        logic [1:0]   ops  [4] = '{DIV, REM, DIV, REM};
        logic [W-1:0] as   [4] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd7, 32'd7};
        logic [W-1:0] bs   [4] = '{32'd2, 32'd2, 32'hFFFF_FFFE, 32'hFFFF_FFFE};
        logic [W-1:0] exps [4] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'd1};
        logic [W-1:0] d;
        int tr, te, ts;
        bit o;
        for (int i = 0; i < 4; i++) begin
            run_one(i, ops[i], as[i], bs[i], d, tr, te, ts, o);
            total++;
            if (d !== exps[i] || o) $display("FAIL signed_%0d got=%h exp=%h", i, d, exps[i]);
            else passed++;
        end
    endtask

    task automatic test_overflow();
        logic [W-1:0] d;
        int tr, te, ts;
        bit o;
        run_one(2, DIV, MINV, '1, d, tr, te, ts, o);
        total++;
        if (d !== MINV) $display("FAIL ovf_div got=%h exp=%h", d, MINV);
        else passed++;
        run_one(2, REM, MINV, '1, d, tr, te, ts, o);
        total++;
        if (d !== '0) $display("FAIL ovf_rem got=%h exp=0", d);
        else passed++;
    endtask

    task automatic test_div_zero();
        logic [W-1:0] d;
        int tr, te, ts;
        bit o;
        run_one(1, DIVU, 32'd5, '0, d, tr, te, ts, o);
        total++;
        if (d !== 32'hFFFF_FFFF) $display("FAIL dz_divu got=%h exp=ffffffff", d);
        else passed++;
        total++;
        if (tr < 0 || ts != tr + 1 || te != -1)
            $display("FAIL dz_timing got rdy=%0d en=%0d rsp=%0d exp rsp=rdy+1 no en", tr, te, ts);
        else passed++;
        run_one(3, REM, 32'hFFFF_FFFB, '0, d, tr, te, ts, o);
        total++;
        if (d !== 32'hFFFF_FFFB) $display("FAIL dz_rem got=%h exp=fffffffb", d);
        else passed++;
    endtask

    task automatic test_random();
        logic [W-1:0] d, a, b, e;
        logic [1:0] op;
        int r, tr, te, ts;
        bit o, tim_ok;
        for (int k = 0; k < 40; k++) begin
            r  = int'($urandom_range(0, N - 1));
            op = 2'($urandom_range(0, 3));
            a  = $urandom;
            b  = $urandom;
            case ($urandom_range(0, 7))
                0: b = '0;
                1: begin a = MINV; b = '1; end
                2: b = 32'($urandom_range(1, 9));
                3: b = ~32'($urandom_range(0, 8));
                default: ;
            endcase
            e = ref_div(op, a, b);
            run_one(r, op, a, b, d, tr, te, ts, o);
            total++;
            if (d !== e || o)
                $display("FAIL rand_data_%0d op=%0d a=%h b=%h got=%h exp=%h", k, op, a, b, d, e);
            else passed++;
            if (b == 0) tim_ok = (tr >= 0) && (ts == tr + 1) && (te == -1);
            else tim_ok = (tr >= 0) && (te == tr + 1) && (ts > te);
            total++;
            if (!tim_ok)
                $display("FAIL rand_timing_%0d rdy=%0d en=%0d rsp=%0d b=%h", k, tr, te, ts, b);
            else passed++;
        end
    endtask

    task automatic test_round_robin();
        int grants[$];
        int pending, nrsp, k;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        for (int i = 0; i < N; i++) begin
            req_op[i] = 2'($urandom_range(0, 3));
            req_dividend[i] = $urandom;
            req_divisor[i] = 32'($urandom_range(1, 1000));
        end
        req_valid = '1;
        pending = -1;
        nrsp = 0;
        for (int n = 0; n < 500 && nrsp < 5; n++) begin
            @(negedge clk);
            if (rsp_valid !== '0) begin
                total++;
                if (pending < 0 || rsp_valid !== (N'(1) << pending)
                    || rsp_data !== ref_div(req_op[pending], req_dividend[pending],
                                            req_divisor[pending]))
                    $display("FAIL rr_rsp got valid=%b data=%h pending=%0d", rsp_valid, rsp_data, pending);
                else passed++;
                nrsp++;
                pending = -1;
            end
            if (req_ready !== '0) begin
                k = -1;
                for (int i = 0; i < N; i++) if (req_ready[i]) k = i;
                if ($countones(req_ready) != 1) k = -2;
                grants.push_back(k);
                pending = k;
                if (grants.size() == 5) begin
                    @(posedge clk);
                    #1 req_valid = '0;
                end
            end
        end
        req_valid = '0;
        total++;
        if (grants.size() != 5 || nrsp != 5)
            $display("FAIL rr_count got grants=%0d rsps=%0d exp 5/5", grants.size(), nrsp);
        else passed++;
        for (int i = 0; i < grants.size(); i++) begin
            total++;
            if (grants[i] != i % N) $display("FAIL rr_order_%0d got=%0d exp=%0d", i, grants[i], i % N);
            else passed++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid();
        logic [W-1:0] d;
        int tr, te, ts;
        bit o, seen_rdy, seen_en, seen_rsp;
        lat_min = 12;
        req_op[1] = DIVU;
        req_dividend[1] = 32'd1000;
        req_divisor[1] = 32'd3;
        req_valid[1] = 1'b1;
        seen_rdy = 1'b0;
        seen_en = 1'b0;
        for (int n = 0; n < 50 && !seen_en; n++) begin
            @(negedge clk);
            if (div_enable === 1'b1) seen_en = 1'b1;
            if (!seen_rdy && req_ready[1] === 1'b1) begin
                seen_rdy = 1'b1;
                @(posedge clk);
                #1 req_valid[1] = 1'b0;
            end
        end
        req_valid[1] = 1'b0;
        total++;
        if (!seen_en) $display("FAIL rmid_launch got no div_enable exp launch");
        else passed++;
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        total++;
        if (busy !== 1'b0 || rsp_valid !== '0)
            $display("FAIL rmid_idle got busy=%b rsp=%b exp 0", busy, rsp_valid);
        else passed++;
        seen_rsp = 1'b0;
        repeat (25) begin
            @(negedge clk);
            if (rsp_valid !== '0) seen_rsp = 1'b1;
        end
        total++;
        if (seen_rsp) $display("FAIL rmid_no_rsp got rsp after reset exp none");
        else passed++;
        lat_min = 1;
        @(posedge clk);
        #1;
        run_one(2, DIV, 32'hFFFF_FF9C, 32'd7, d, tr, te, ts, o);
        total++;
        if (d !== 32'hFFFF_FFF2) $display("FAIL rmid_after got=%h exp=fffffff2", d);
        else passed++;
    endtask

    task automatic test_stray_finish();
        bit seen;
        stray = 1'b1;
        @(posedge clk);
        #1 stray = 1'b0;
        seen = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (rsp_valid !== '0 || busy !== 1'b0) seen = 1'b1;
        end
        total++;
        if (seen) $display("FAIL stray_finish got activity exp idle");
        else passed++;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_unsigned();
        test_signed();
        test_overflow();
        test_div_zero();
        test_stray_finish();
        test_random();
        test_round_robin();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
